// File: rtl/mux_tree_reg.sv
// mux_tree_reg: CHANNELS-to-1 selection of WIDTH-bit words through a
// pipelined binary tree of registered 2:1 muxes. A valid bit and the full
// effective select (channel tag) travel alongside the data, so out,
// out_valid and out_sel appear exactly SEL_W enabled cycles after input.
// An internal round-robin counter can supply the select (auto=1).
//
// Optional feature macro: MUX_TREE_REG_PARITY_EN adds out_parity, the even
// parity (XOR) of the selected word, pipelined with matching latency.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   enable     global clock enable (0 = stall, every register holds)
//   in_valid   current input slice is meaningful
//   data_in    flattened inputs, channel c at [c*WIDTH +: WIDTH]
//   sel        external channel select (used when auto=0)
//   auto       1 = round-robin scan counter supplies the select
//   out        selected word
//   out_valid  out carries a valid word
//   out_sel    channel index that produced out
//   out_parity XOR of the selected word (MUX_TREE_REG_PARITY_EN only)
module mux_tree_reg #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      auto,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_sel
`ifdef MUX_TREE_REG_PARITY_EN
  ,
  output logic                      out_parity
`endif
);

  localparam int unsigned L = SEL_W;

  logic [WIDTH-1:0] leaf [CHANNELS];
  logic [SEL_W-1:0] scan_cnt;
  logic [SEL_W-1:0] eff_sel;

  // Tree nodes stored as a binary heap: node 0 is the output register,
  // node j has children 2j+1 (lower channels) and 2j+2 (upper channels).
  // Stage k occupies nodes (CHANNELS>>k)-1 .. 2*(CHANNELS>>k)-2.
  logic [WIDTH-1:0] node  [CHANNELS-1];
  logic [L-1:0]     v_q;
  logic [SEL_W-1:0] t_q   [L];

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      leaf[c] = data_in[c*WIDTH +: WIDTH];
    end
  end

  assign eff_sel = auto ? scan_cnt : sel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      v_q      <= '0;
      for (int unsigned n = 0; n < CHANNELS - 1; n++) begin
        node[n] <= '0;
      end
      for (int unsigned k = 0; k < L; k++) begin
        t_q[k] <= '0;
      end
    end else if (enable) begin
      // Stage 1 picks between adjacent input channels with eff_sel bit 0.
      for (int unsigned i = 0; i < (CHANNELS >> 1); i++) begin
        node[(CHANNELS >> 1) - 1 + i] <= eff_sel[0] ? leaf[2*i + 1] : leaf[2*i];
      end
      // Stage k uses bit k-1 of the tag travelling with stage k-1's data.
      for (int unsigned k = 2; k <= L; k++) begin
        for (int unsigned i = 0; i < (CHANNELS >> k); i++) begin
          node[(CHANNELS >> k) - 1 + i] <= t_q[k-2][k-1]
            ? node[2*(CHANNELS >> k) + 2*i]
            : node[2*(CHANNELS >> k) - 1 + 2*i];
        end
      end
      v_q[0] <= in_valid;
      t_q[0] <= eff_sel;
      for (int unsigned k = 1; k < L; k++) begin
        v_q[k] <= v_q[k-1];
        t_q[k] <= t_q[k-1];
      end
      // Power-of-two channel count makes the natural wrap the round-robin wrap.
      if (in_valid && auto) begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  assign out       = node[0];
  assign out_valid = v_q[L-1];
  assign out_sel   = t_q[L-1];

`ifdef MUX_TREE_REG_PARITY_EN
  logic [L-1:0] par_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_q <= '0;
    end else if (enable) begin
      par_q[0] <= ^leaf[eff_sel];
      for (int unsigned k = 1; k < L; k++) begin
        par_q[k] <= par_q[k-1];
      end
    end
  end

  assign out_parity = par_q[L-1];
`endif

endmodule

// File: tb/tb_mux_tree_reg.sv
// Bench for mux_tree_reg (WIDTH=3, CHANNELS=4): a delay-line reference
// model plus directed vectors with hand-computed expectations.
module tb_mux_tree_reg;

  localparam int W  = 3;
  localparam int C  = 4;
  localparam int SW = 2;
  localparam int L  = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic            in_valid;
  logic [C*W-1:0]  data_in;
  logic [SW-1:0]   sel;
  logic            auto;
  logic [W-1:0]    out;
  logic            out_valid;
  logic [SW-1:0]   out_sel;
`ifdef MUX_TREE_REG_PARITY_EN
  logic            out_parity;
`endif

  int checks = 0;
  int errors = 0;

  mux_tree_reg #(.WIDTH(W), .CHANNELS(C)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .sel       (sel),
    .auto      (auto),
    .out       (out),
    .out_valid (out_valid),
    .out_sel   (out_sel)
`ifdef MUX_TREE_REG_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  // Reference model: each enabled edge pushes {valid, selected word, channel,
  // parity} into an L-deep delay line; the oldest entry is the expected output.
  int mv [L];
  int md [L];
  int ms [L];
  int mp [L];
  int mcnt;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < L; i++) begin
        mv[i] = 0; md[i] = 0; ms[i] = 0; mp[i] = 0;
      end
      mcnt = 0;
    end else if (enable) begin
      int es;
      int w;
      es = auto ? mcnt : int'(sel);
      w  = int'((data_in >> (es * W)) & 12'd7);
      for (int i = L - 1; i > 0; i--) begin
        mv[i] = mv[i-1]; md[i] = md[i-1]; ms[i] = ms[i-1]; mp[i] = mp[i-1];
      end
      mv[0] = int'(in_valid);
      md[0] = w;
      ms[0] = es;
      mp[0] = $countones(w) % 2;
      if (in_valid && auto) mcnt = (mcnt + 1) % C;
    end
  end

  always @(negedge clock) begin
    chk("model_valid", int'(out_valid), mv[L-1]);
    if (mv[L-1] != 0) begin
      chk("model_data", int'(out), md[L-1]);
      chk("model_sel", int'(out_sel), ms[L-1]);
`ifdef MUX_TREE_REG_PARITY_EN
      chk("model_parity", int'(out_parity), mp[L-1]);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int scan_sel [6] = '{0, 1, 2, 3, 0, 1};
  int scan_dat [6] = '{1, 2, 5, 7, 1, 2};

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b1;
    auto     = 1'b0;
    sel      = 2'd2;
    data_in  = {3'd7, 3'd5, 3'd2, 3'd1};

    // Reset and two-cycle latency
    tick;
    chk("rst_out", int'(out), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sel", int'(out_sel), 0);
`ifdef MUX_TREE_REG_PARITY_EN
    chk("rst_parity", int'(out_parity), 0);
`endif
    reset = 1'b0;
    tick;
    chk("lat_early_valid", int'(out_valid), 0);
    sel = 2'd0;
    tick;
    chk("lat_out", int'(out), 5);
    chk("lat_sel", int'(out_sel), 2);
    chk("lat_valid", int'(out_valid), 1);

    // Streaming with sel 0,1,3,2
    sel = 2'd1;
    tick;
    chk("stream_out0", int'(out), 1);
`ifdef MUX_TREE_REG_PARITY_EN
    chk("stream_par0", int'(out_parity), 1);
`endif
    sel = 2'd3;
    tick;
    chk("stream_out1", int'(out), 2);
`ifdef MUX_TREE_REG_PARITY_EN
    chk("stream_par1", int'(out_parity), 1);
`endif
    sel = 2'd2;
    tick;
    chk("stream_out3", int'(out), 7);
    chk("stream_valid3", int'(out_valid), 1);
`ifdef MUX_TREE_REG_PARITY_EN
    chk("stream_par3", int'(out_parity), 1);
`endif
    tick;
    chk("stream_out2", int'(out), 5);
    chk("stream_valid2", int'(out_valid), 1);
`ifdef MUX_TREE_REG_PARITY_EN
    chk("stream_par2", int'(out_parity), 0);
`endif

    // Auto scan for six words
    auto = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (i >= 1) begin
        chk("scan_sel", int'(out_sel), scan_sel[i-1]);
        chk("scan_data", int'(out), scan_dat[i-1]);
      end
    end

    // One-cycle bubble: counter holds, out_valid drops two cycles later
    in_valid = 1'b0;
    tick;
    chk("scan_sel_last", int'(out_sel), 1);
    chk("scan_data_last", int'(out), 2);
    in_valid = 1'b1;
    tick;
    chk("bubble_valid", int'(out_valid), 0);
    tick;
    chk("after_bubble_valid", int'(out_valid), 1);
    chk("after_bubble_sel", int'(out_sel), 2);
    chk("after_bubble_data", int'(out), 5);

    // Three-cycle stall
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_sel", int'(out_sel), 2);
      chk("stall_data", int'(out), 5);
      chk("stall_valid", int'(out_valid), 1);
    end
    enable = 1'b1;
    tick;
    chk("resume_sel0", int'(out_sel), 3);
    chk("resume_data0", int'(out), 7);
    tick;
    chk("resume_sel1", int'(out_sel), 0);
    chk("resume_data1", int'(out), 1);

    // Asynchronous reset between edges with words in flight
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out", int'(out), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_sel", int'(out_sel), 0);
    tick;
    reset = 1'b0;
    tick;
    chk("post_rst_early_valid", int'(out_valid), 0);
    tick;
    chk("post_rst_sel", int'(out_sel), 0);
    chk("post_rst_data", int'(out), 1);
    chk("post_rst_valid", int'(out_valid), 1);
    tick;
    chk("post_rst_sel_next", int'(out_sel), 1);
    chk("post_rst_data_next", int'(out), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_tree_reg.md
Name: mux_tree_reg

Overview:
- Parametrised successor to the 2:1 registered mux bank: CHANNELS-to-1 selection of WIDTH-bit words.
- Built as a pipelined binary tree of registered 2:1 mux stages, with a valid bit and channel tag carried alongside the data.
- Adds an internal round-robin scan mode, so a datapath can time-multiplex channels without an external sequencer.
- Sits between per-channel datapath registers and a shared downstream unit.

Parameters:
- WIDTH, 3, bits per channel word.
- CHANNELS, 4, number of input channels; power of two, >= 2.
- SEL_W, $clog2(CHANNELS), select/tag width (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global clock-enable; 0 freezes every register (stall).
- in_valid  in  1  current input slice is meaningful.
- data_in  in  CHANNELS*WIDTH  flattened inputs; channel c occupies [c*WIDTH +: WIDTH].
- sel  in  SEL_W  external channel select; used when auto=0.
- auto  in  1  1 = internal round-robin counter supplies the select.
- out  out  WIDTH  selected word.
- out_valid  out  1  out carries a valid word.
- out_sel  out  SEL_W  channel index that produced out.

Behaviour:
- Reset: asynchronous, active-high. While asserted, all stage data regs, valid bits, tag regs, the scan counter, out, out_valid and out_sel = 0. Reset mid-stream discards every in-flight word.
- Effective select: eff_sel = auto ? scan_cnt : sel. Sampled on the same edge as data_in.
- Tree structure:
  - L = SEL_W stages.
  - Stage k (k = 1..L) holds CHANNELS>>k registered 2:1 muxes.
  - Stage k selects with eff_sel bit k-1 (LSB first).
  - Unused upper select bits, valid and the full eff_sel tag are pipelined with the data.
  - Stage L is the output register.
  - CHANNELS=2 degenerates to the original single-stage registered mux.
- Latency: exactly L enabled cycles from input to out / out_valid / out_sel. Throughput is one word per enabled cycle.
- enable = 0: no register changes, including the scan counter. Outputs hold. On re-enable the pipeline resumes with no loss or duplication.
- enable = 1, in_valid = 0:
  - Data and tag registers still shift (don't-care contents).
  - A valid = 0 bubble enters and emerges L cycles later as out_valid = 0.
  - out holds whatever the pipeline produces; downstream must qualify it with out_valid.
- Scan counter:
  - SEL_W bits; increments when enable & in_valid & auto.
  - Wraps CHANNELS-1 -> 0.
  - Holds when auto = 0.
  - Toggling auto takes effect on the next enabled edge; the counter resumes from its held value and is not cleared.
- Simultaneous auto toggle and in_valid: the select used is the one chosen by auto on that edge.
- sel is never out of range, because CHANNELS is a power of two.

Optional Feature:
- Macro: MUX_TREE_REG_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR of the selected channel word (even parity).
  - Computed at input, then pipelined with matching latency, stall and reset behaviour.
  - Reset value 0.
- Undefined: port absent, no extra registers, all other behaviour identical.

Test Plan:
- Reset/latency (CHANNELS=4, WIDTH=3):
  - Stimulus: reset=1, then release; data_in = {ch3=7, ch2=5, ch1=2, ch0=1}, sel=2, auto=0, in_valid=1, enable=1.
  - Required: during reset all outputs 0; two edges after release, out=5, out_sel=2, out_valid=1.
- Streaming:
  - Stimulus: sel sequence 0,1,3,2 on consecutive cycles with fixed data.
  - Required: out = 1,2,7,5 on cycles 2..5, out_valid continuously 1.
- Stall:
  - Stimulus: drop enable for 3 cycles mid-stream.
  - Required: out, out_valid, out_sel and the scan counter all frozen; sequence resumes without skip or repeat.
- Auto scan:
  - Stimulus: auto=1, in_valid=1 for 6 cycles.
  - Required: out_sel = 0,1,2,3,0,1 with the matching data.
  - Stimulus: in_valid=0 for 1 cycle.
  - Required: counter holds; a single out_valid=0 bubble appears 2 cycles later.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges with valid words in flight.
  - Required: out=0, out_valid=0, out_sel=0 immediately; counter restarts at 0.
- Parity (MUX_TREE_REG_PARITY_EN defined):
  - Stimulus: select ch3=7, then ch1=2.
  - Required: out_parity = 1, then 1, aligned with out.
